// File: rtl/mem_byte_sequencer.sv
// Arbitrates fetch and data ports onto a byte-wide handshake RAM.
// Each access is split into big-endian byte transfers (SETUP/STROBE/RELEASE per byte).
module mem_byte_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              IReq,
  input  logic [31:0]       IAddr,
  output logic              IAck,
  output logic [31:0]       IData,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [1:0]        DSize,
  input  logic [31:0]       DAddr,
  input  logic [31:0]       DWData,
  output logic              DAck,
  output logic [31:0]       DRData,
  output logic              Err,
  output logic              Busy,
  output logic              Enable,
  output logic              MOV,
  output logic              RW,
  output logic [ADDR_W-1:0] Address,
  output logic [7:0]        DataOut,
  input  logic [7:0]        DataIn,
  input  logic              MOC
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, DONE} state_t;

  typedef struct packed {
    logic              dport;
    logic              wr;
    logic [1:0]        last;   // index of final byte: 0, 1 or 3
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
  } req_t;

  state_t        state;
  req_t          r;
  logic [1:0]    k;
  logic [TW-1:0] tcnt;
  logic [31:0]   rdat;
  logic          last_d;

  logic          pick_d, g_wr, g_mis;
  logic [31:0]   g_addr;
  logic [1:0]    g_last;
  logic          fin, ferr, fport;
  logic [31:0]   fdat;
  logic          unused_ok;

  assign unused_ok = ^g_addr[31:ADDR_W];

  // Byte idx of an item whose last byte index is 'last'; idx 0 is the MSB.
  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] last,
                                         input logic [1:0] idx);
    logic [4:0] sh;
    sh = {last - idx, 3'b000};
    return d[sh +: 8];
  endfunction

  always_comb begin
    pick_d = DReq && !(IReq && last_d);
    g_addr = pick_d ? DAddr : IAddr;
    g_wr   = pick_d && DWrite;
    if (!pick_d) g_last = 2'd3;
    else begin
      case (DSize)
        2'b00:   g_last = 2'd0;
        2'b01:   g_last = 2'd1;
        default: g_last = 2'd3;
      endcase
    end
    g_mis = (g_last == 2'd3 && g_addr[1:0] != 2'b00) || (g_last == 2'd1 && g_addr[0]);
  end

  // Completion: misaligned grant, normal finish, or handshake timeout.
  always_comb begin
    fin   = 1'b0;
    ferr  = 1'b0;
    fdat  = rdat;
    fport = r.dport;
    case (state)
      IDLE: begin
        fin   = (IReq || DReq) && g_mis;
        ferr  = 1'b1;
        fdat  = '0;
        fport = pick_d;
      end
      STROBE: begin
        fin  = !MOC && tcnt == TLAST;
        ferr = 1'b1;
      end
      RELEASE: begin
        if (!MOC) fin = (k == r.last);
        else begin
          fin  = (tcnt == TLAST);
          ferr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      Enable  <= 1'b0;
      MOV     <= 1'b0;
      RW      <= 1'b1;
      Address <= '0;
      DataOut <= '0;
      IAck    <= 1'b0;
      DAck    <= 1'b0;
      IData   <= '0;
      DRData  <= '0;
      Err     <= 1'b0;
      Busy    <= 1'b0;
      last_d  <= 1'b1;
      r       <= '0;
      k       <= '0;
      tcnt    <= '0;
      rdat    <= '0;
    end else begin
      IAck <= 1'b0;
      DAck <= 1'b0;
      case (state)
        IDLE: begin
          if (IReq || DReq) begin
            r    <= '{dport: pick_d, wr: g_wr, last: g_last,
                      base: g_addr[ADDR_W-1:0], wdata: DWData};
            k    <= '0;
            tcnt <= '0;
            rdat <= '0;
            Busy <= 1'b1;
            if (!g_mis) begin
              state   <= SETUP;
              Enable  <= 1'b1;
              Address <= g_addr[ADDR_W-1:0];
              RW      <= ~g_wr;
              DataOut <= g_wr ? byte_of(DWData, g_last, 2'd0) : 8'h00;
            end
          end
        end
        SETUP: begin
          state <= STROBE;
          MOV   <= 1'b1;
          tcnt  <= '0;
        end
        STROBE: begin
          if (MOC) begin
            if (!r.wr) rdat[{r.last - k, 3'b000} +: 8] <= DataIn;
            state <= RELEASE;
            MOV   <= 1'b0;
            tcnt  <= '0;
          end else tcnt <= tcnt + 1'b1;
        end
        RELEASE: begin
          if (!MOC && k != r.last) begin
            k       <= k + 2'd1;
            state   <= SETUP;
            Address <= r.base + ADDR_W'({1'b0, k} + 3'd1);
            DataOut <= r.wr ? byte_of(r.wdata, r.last, k + 2'd1) : 8'h00;
          end else tcnt <= tcnt + 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          Busy   <= 1'b0;
          Err    <= 1'b0;
          IData  <= '0;
          DRData <= '0;
          last_d <= r.dport;
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        state  <= DONE;
        Enable <= 1'b0;
        MOV    <= 1'b0;
        Err    <= ferr;
        if (fport) begin
          DAck   <= 1'b1;
          DRData <= fdat;
        end else begin
          IAck  <= 1'b1;
          IData <= fdat;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a behavioural byte RAM on the handshake.
module tb_mem_byte_sequencer;
  logic        Clk = 1'b0;
  logic        Reset_n, IReq, DReq, DWrite, MOC;
  logic [31:0] IAddr, DAddr, DWData, IData, DRData;
  logic [1:0]  DSize;
  logic        IAck, DAck, Err, Busy, Enable, MOV, RW;
  logic [8:0]  Address;
  logic [7:0]  DataOut, DataIn;

  logic [7:0]  mem [0:511];
  logic        stuck = 1'b0;
  int          total = 0, bad = 0;
  int          en_cnt = 0, dack_cnt = 0;

  always #5 Clk = ~Clk;

  mem_byte_sequencer #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IData(IData),
    .DReq(DReq), .DWrite(DWrite), .DSize(DSize), .DAddr(DAddr), .DWData(DWData),
    .DAck(DAck), .DRData(DRData), .Err(Err), .Busy(Busy),
    .Enable(Enable), .MOV(MOV), .RW(RW), .Address(Address),
    .DataOut(DataOut), .DataIn(DataIn), .MOC(MOC)
  );

  // Ideal RAM: MOC follows Enable&MOV half a cycle later unless stuck.
  assign DataIn = mem[Address];
  always @(negedge Clk) begin
    MOC <= stuck ? 1'b0 : (Enable && MOV);
    if (Enable && MOV && !RW) mem[Address] <= DataOut;
    if (Enable) en_cnt <= en_cnt + 1;
    if (DAck) dack_cnt <= dack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic dp, input logic wr, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input int ecyc,
                      input logic [31:0] ed, input logic ee, input string tag);
    int   cyc;
    logic got;
    @(posedge Clk); #1;
    if (dp) begin
      DReq = 1; DWrite = wr; DSize = sz; DAddr = a; DWData = wd;
    end else begin
      IReq = 1; IAddr = a;
    end
    cyc = 0; got = 0;
    while (!got && cyc < 64) begin
      @(posedge Clk); #1;
      cyc++;
      got = dp ? DAck : IAck;
    end
    DReq = 0; IReq = 0;
    chk({tag, ".ack"}, 32'(got), 32'd1);
    chk({tag, ".cyc"}, cyc, ecyc);
    chk({tag, ".data"}, dp ? DRData : IData, ed);
    chk({tag, ".err"}, 32'(Err), 32'(ee));
    chk({tag, ".ramoff"}, {Enable, MOV}, 32'd0);
    @(posedge Clk); #1;
    chk({tag, ".idle"}, {IAck, DAck, Busy}, 32'd0);
  endtask

  // Both ports request at once; records which acknowledges first.
  task automatic pair(input logic fetch_first, input logic [31:0] idat,
                      input logic [31:0] ddat, input string tag);
    int seq, ipos, dpos, cyc;
    @(posedge Clk); #1;
    IReq = 1; IAddr = 32'h0;
    DReq = 1; DWrite = 0; DSize = 2'b10; DAddr = 32'h10;
    seq = 0; ipos = 0; dpos = 0; cyc = 0;
    while ((IReq || DReq) && cyc < 100) begin
      @(posedge Clk); #1;
      cyc++;
      if (IAck) begin seq++; ipos = seq; chk({tag, ".idata"}, IData, idat); IReq = 0; end
      if (DAck) begin seq++; dpos = seq; chk({tag, ".ddata"}, DRData, ddat); DReq = 0; end
    end
    IReq = 0; DReq = 0;
    chk({tag, ".ipos"}, ipos, fetch_first ? 32'd1 : 32'd2);
    chk({tag, ".dpos"}, dpos, fetch_first ? 32'd2 : 32'd1);
  endtask

  initial begin
    int snap_en, snap_ack;
    Reset_n = 0; IReq = 0; DReq = 0; DWrite = 0; DSize = 0;
    IAddr = 0; DAddr = 0; DWData = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.en_mov", {Enable, MOV}, 32'd0);
    chk("rst.rw", 32'(RW), 32'd1);
    chk("rst.addr", 32'(Address), 32'd0);
    chk("rst.dout", 32'(DataOut), 32'd0);
    chk("rst.flags", {IAck, DAck, Err, Busy}, 32'd0);
    chk("rst.data", IData | DRData, 32'd0);
    Reset_n = 1;

    xfer(1, 1, 2'b10, 32'h10, 32'hDEADBEEF, 13, 32'h0, 0, "st_w");
    chk("mem10", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
    xfer(1, 0, 2'b10, 32'h10, 32'h0, 13, 32'hDEADBEEF, 0, "ld_w");
    xfer(1, 0, 2'b00, 32'h12, 32'h0, 4, 32'h000000BE, 0, "ld_b");
    xfer(1, 0, 2'b01, 32'h12, 32'h0, 7, 32'h0000BEEF, 0, "ld_h");
    xfer(1, 0, 2'b11, 32'h10, 32'h0, 13, 32'hDEADBEEF, 0, "ld_sz3");
    xfer(1, 1, 2'b01, 32'h20, 32'h1234CAFE, 7, 32'h0, 0, "st_h");
    xfer(1, 1, 2'b00, 32'h22, 32'hFFFFFF77, 4, 32'h0, 0, "st_b");
    chk("mem20", {mem[32], mem[33], mem[34]}, 32'h00CAFE77);
    xfer(1, 1, 2'b10, 32'h0, 32'h11223344, 13, 32'h0, 0, "st_w0");

    // Data has been served last since reset, so fetch wins this tie.
    pair(1, 32'h11223344, 32'hDEADBEEF, "tie1");
    // Serve fetch alone so data wins the next tie.
    xfer(0, 0, 2'b10, 32'h10, 32'h0, 13, 32'hDEADBEEF, 0, "fetch");
    pair(0, 32'h11223344, 32'hDEADBEEF, "tie2");

    snap_en = en_cnt;
    xfer(1, 0, 2'b10, 32'h11, 32'h0, 1, 32'h0, 1, "mis_w");
    xfer(1, 1, 2'b01, 32'h13, 32'hFFFF, 1, 32'h0, 1, "mis_h");
    xfer(0, 0, 2'b10, 32'h2, 32'h0, 1, 32'h0, 1, "mis_f");
    chk("mis.noenable", en_cnt, snap_en);
    chk("mis.memintact", {mem[18], mem[19]}, 32'h0000BEEF);

    stuck = 1;
    xfer(1, 0, 2'b00, 32'h10, 32'h0, 17, 32'h0, 1, "tmo");
    stuck = 0;
    xfer(1, 0, 2'b01, 32'h10, 32'h0, 7, 32'h0000DEAD, 0, "post_tmo");

    xfer(1, 1, 2'b10, 32'h40, 32'hA5A5A5A5, 13, 32'h0, 0, "st_a5");
    snap_ack = dack_cnt;
    @(posedge Clk); #1;
    DReq = 1; DWrite = 1; DSize = 2'b10; DAddr = 32'h40; DWData = 32'h12345678;
    repeat (6) @(posedge Clk);
    #1;
    chk("mid.addr", 32'(Address), 32'h41);
    Reset_n = 0; DReq = 0;
    @(posedge Clk); #1;
    chk("mid.en_mov", {Enable, MOV}, 32'd0);
    chk("mid.rw_addr", {RW, Address}, 32'h200);
    chk("mid.flags", {IAck, DAck, Err, Busy, DataOut}, 32'd0);
    Reset_n = 1;
    repeat (3) @(posedge Clk);
    #1;
    chk("mid.noack", dack_cnt, snap_ack);
    chk("mid.mem", {mem[64], mem[65], mem[66], mem[67]}, 32'h1234A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
